polar_code_len: RTL and testbench
=================================

POLAR_CODE_LEN -- requirements
Module: polar_code_len

Interface
REQ-001 Parameter E_W, default 15, width of rate-matched length E.
REQ-002 Parameter K_W, default 10, width of information length K (incl. CRC).
REQ-003 Parameter N_MAX_LOG, default 10, upper bound nmax on log2(N); 9 for downlink, 10 for uplink.
REQ-004 Parameter N_MIN_LOG, default 5, lower bound nmin on log2(N).
REQ-005 Port clk_i, in, 1: single clock; one clock; reset is asynchronous and active-low.
REQ-006 Port rst_ni, in, 1: asynchronous active-low reset.
REQ-007 Port e_i, in, E_W: rate-matched length E.
REQ-008 Port k_i, in, K_W: information length K.
REQ-009 Port valid_i / ready_o, in / out, 1 each: input handshake.
REQ-010 Port n_log_o, out, 4: selected n = log2(N).
REQ-011 Port n_o, out, N_MAX_LOG+1: mother code length N = 2^n.
REQ-012 Port err_o, out, 1: E = 0 or K = 0.
REQ-013 Port valid_o / ready_i, out / in, 1 each: output handshake.

Function
REQ-014 The block shall compute n = max(min(n1, n2, nmax), nmin) per TS 38.212 clause 5.3.1, with Rmin = 1/8.
REQ-015 c = ceil_log2(E), where ceil_log2(1) = 0 and ceil_log2(x) = smallest c with 2^c >= x.
REQ-016 n1 = c-1 when c >= 1 and 8*E <= 9*2^(c-1) and 16*K < 9*E; otherwise n1 = c. Exact integer arithmetic, no truncation: products sized E_W+4 and K_W+4 bits.
REQ-017 n2 = ceil_log2(K) + 3.
REQ-018 n_o shall equal 1 << n_log_o.
REQ-019 When E = 0 or K = 0, err_o = 1 and n_log_o = N_MIN_LOG; otherwise err_o = 0.
REQ-020 Three-stage pipeline: S1 registers inputs and computes c and ceil_log2(K); S2 computes n1 and n2; S3 clamps and drives the outputs. Latency is 3 cycles from input handshake to valid_o when ready_i stays high.
REQ-021 Throughput is one result per cycle while ready_i = 1.
REQ-022 A transfer occurs on a rising edge with valid and ready both high. Inputs are sampled only on a transfer.
REQ-023 ready_o = !S1_full | (S1 advances this cycle). A stage advances when its successor is empty or advancing. S3 advances on ready_i.
REQ-024 While valid_o = 1 and ready_i = 0, n_log_o, n_o and err_o shall hold stable and valid_o shall stay high.
REQ-025 Results shall leave in input order, with no loss or duplication under any valid_i/ready_i pattern.
REQ-026 A simultaneous S3 drain and S1 fill in the same cycle shall be accepted without a bubble.

Reset
REQ-027 On rst_ni = 0, all stage-valid flags clear asynchronously. valid_o = 0, ready_o = 1 after reset, n_log_o = N_MIN_LOG, n_o = 2^N_MIN_LOG, err_o = 0.
REQ-028 Reset during operation discards all in-flight results. No output appears for inputs accepted before the reset.
REQ-029 Datapath registers other than the outputs need no reset.

Structure
REQ-030 The shared polar package shall hold N_MIN_LOG, the N_MAX_LOG defaults (DL = 9, UL = 10) and the RMIN_SHIFT = 3 constant.
REQ-031 A parametrised combinational sub-module ceil_log2 (parameter W, input W bits, output $clog2(W)+1 bits) shall be instantiated twice, once for E and once for K.

Verification
REQ-032 N_MAX_LOG = 9; E = 864, K = 56 -> c = 10, n1 = 10, n2 = 9, n_log_o = 9, n_o = 512, err_o = 0, valid_o 3 cycles after accept.
REQ-033 N_MAX_LOG = 10; E = 560, K = 100 -> n1 = 9 (reduction taken), n2 = 10, n_log_o = 9, n_o = 512. E = 600, K = 100 -> n_log_o = 10, n_o = 1024.
REQ-034 E = 20, K = 12 -> n_log_o = 5, n_o = 32. E = 1, K = 1 -> clamp to n_log_o = 5. K = 0 -> err_o = 1, n_log_o = 5.
REQ-035 Back-to-back 8 inputs with ready_i toggling on a random pattern -> 8 outputs in order, stable while stalled. ready_o = 0 only when the pipeline is full and ready_i = 0.
REQ-036 Assert rst_ni = 0 with 2 results in flight -> valid_o drops immediately, no stale output after release, ready_o = 1.

Source files
------------

// File: rtl/polar_code_len_pkg.sv
// Shared polar-code constants.
//   N_MIN_LOG_DEF : lower bound nmin on log2(N)
//   N_MAX_LOG_DL  : nmax for downlink
//   N_MAX_LOG_UL  : nmax for uplink
//   RMIN_SHIFT    : log2(1/Rmin), Rmin = 1/8
package polar_code_len_pkg;
    localparam int unsigned N_MIN_LOG_DEF = 5;
    localparam int unsigned N_MAX_LOG_DL  = 9;
    localparam int unsigned N_MAX_LOG_UL  = 10;
    localparam int unsigned RMIN_SHIFT    = 3;
endpackage

// File: rtl/polar_code_len_ceil_log2.sv
// Combinational ceil(log2(x)).
//   x_i : W-bit operand
//   y_o : smallest c with 2^c >= x; 0 for x = 0 or x = 1
module polar_code_len_ceil_log2 #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]       x_i,
    output logic [$clog2(W):0] y_o
);
    localparam int unsigned OW = $clog2(W) + 1;

    logic [W-1:0] xm1;

    // ceil_log2(x) is the bit length of x-1.
    always_comb begin
        xm1 = x_i - W'(1);
        y_o = '0;
        if (x_i != '0) begin
            for (int unsigned i = 0; i < W; i++) begin
                if (xm1[i]) y_o = OW'(i + 1);
            end
        end
    end
endmodule

// File: rtl/polar_code_len.sv
// Polar mother-code length selection, n = max(min(n1, n2, nmax), nmin).
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   e_i, k_i          : rate-matched length E, information length K
//   valid_i / ready_o : input handshake
//   n_log_o, n_o      : selected n and N = 2^n
//   err_o             : E = 0 or K = 0
//   valid_o / ready_i : output handshake
// Three-stage pipeline: S1 registers E/K (ceil_log2 follows), S2 holds
// c and ceil_log2(K) for n1/n2, S3 registers the clamped result.
module polar_code_len
    import polar_code_len_pkg::*;
#(
    parameter int unsigned E_W       = 15,
    parameter int unsigned K_W       = 10,
    parameter int unsigned N_MAX_LOG = N_MAX_LOG_UL,
    parameter int unsigned N_MIN_LOG = N_MIN_LOG_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [E_W-1:0]       e_i,
    input  logic [K_W-1:0]       k_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [3:0]           n_log_o,
    output logic [N_MAX_LOG:0]   n_o,
    output logic                 err_o,
    output logic                 valid_o,
    input  logic                 ready_i
);
    localparam int unsigned CE_W = $clog2(E_W) + 1;
    localparam int unsigned CK_W = $clog2(K_W) + 1;
    localparam int unsigned PW   = ((E_W > K_W) ? E_W : K_W) + 4;
    localparam int unsigned NW   = 6;
    localparam int unsigned NOW  = N_MAX_LOG + 1;

    // Stage 1
    logic            v1_q;
    logic [E_W-1:0]  e1_q;
    logic [K_W-1:0]  k1_q;
    logic [CE_W-1:0] c1;
    logic [CK_W-1:0] ck1;

    // Stage 2
    logic            v2_q;
    logic [E_W-1:0]  e2_q;
    logic [K_W-1:0]  k2_q;
    logic [CE_W-1:0] c2_q;
    logic [CK_W-1:0] ck2_q;

    // Stage 3 (outputs)
    logic            valid_q;
    logic [3:0]      n_log_q;
    logic [NOW-1:0]  n_q;
    logic            err_q;

    logic            en1, en2, en3;
    logic [PW-1:0]   e_p, k_p, e8, e9, k16, lim;
    logic [NW-1:0]   n1, n2, nsel;
    logic            err_d;
    logic [3:0]      n_log_d;
    logic [NOW-1:0]  n_d;

    polar_code_len_ceil_log2 #(.W(E_W)) u_clog_e (.x_i(e1_q), .y_o(c1));
    polar_code_len_ceil_log2 #(.W(K_W)) u_clog_k (.x_i(k1_q), .y_o(ck1));

    // A stage may load when it is empty or its contents move on this edge.
    assign en3     = !valid_q || ready_i;
    assign en2     = !v2_q || en3;
    assign en1     = !v1_q || en2;
    assign ready_o = en1;

    always_comb begin
        e_p   = PW'(e2_q);
        k_p   = PW'(k2_q);
        e8    = e_p << RMIN_SHIFT;
        e9    = e8 + e_p;
        k16   = k_p << (RMIN_SHIFT + 1);
        lim   = '0;
        if (c2_q != '0) lim = PW'(9) << (c2_q - 1'b1);
        n1 = NW'(c2_q);
        if (c2_q != '0 && e8 <= lim && k16 < e9) n1 = NW'(c2_q) - NW'(1);
        n2 = NW'(ck2_q) + NW'(RMIN_SHIFT);
        err_d = (e2_q == '0) || (k2_q == '0);
        nsel = n1;
        if (n2 < nsel) nsel = n2;
        if (NW'(N_MAX_LOG) < nsel) nsel = NW'(N_MAX_LOG);
        if (nsel < NW'(N_MIN_LOG) || err_d) nsel = NW'(N_MIN_LOG);
        n_log_d = 4'(nsel);
        n_d     = NOW'(1) << nsel;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            valid_q <= 1'b0;
            n_log_q <= 4'(N_MIN_LOG);
            n_q     <= NOW'(1) << N_MIN_LOG;
            err_q   <= 1'b0;
        end else begin
            if (en1) v1_q <= valid_i;
            if (en2) v2_q <= v1_q;
            if (en3) begin
                valid_q <= v2_q;
                if (v2_q) begin
                    n_log_q <= n_log_d;
                    n_q     <= n_d;
                    err_q   <= err_d;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (en1 && valid_i) begin
            e1_q <= e_i;
            k1_q <= k_i;
        end
        if (en2 && v1_q) begin
            e2_q  <= e1_q;
            k2_q  <= k1_q;
            c2_q  <= c1;
            ck2_q <= ck1;
        end
    end

    assign valid_o = valid_q;
    assign n_log_o = n_log_q;
    assign n_o     = n_q;
    assign err_o   = err_q;
endmodule

// File: tb/tb_polar_code_len.sv
module tb_polar_code_len;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] e;
    logic [9:0]  k;
    logic        valid_i;
    logic        ready_i = 1'b1;

    logic        rdy_u, err_u, vo_u;
    logic [3:0]  nlog_u;
    logic [10:0] n_u;
    logic        rdy_d, err_d, vo_d;
    logic [3:0]  nlog_d;
    logic [9:0]  n_d;

    typedef struct { int nlog; int n; int err; } exp_t;
    exp_t q_u[$];
    exp_t q_d[$];
    exp_t xu, xd;

    int checks = 0;
    int passed = 0;
    int rmode = 0;   // 0: ready_i high, 1: random, 2: ready_i low

    always #5 clk = ~clk;

    polar_code_len #(.E_W(15), .K_W(10), .N_MAX_LOG(10), .N_MIN_LOG(5)) u_ul (
        .clk_i(clk), .rst_ni(rst_n), .e_i(e), .k_i(k), .valid_i(valid_i),
        .ready_o(rdy_u), .n_log_o(nlog_u), .n_o(n_u), .err_o(err_u),
        .valid_o(vo_u), .ready_i(ready_i));

    polar_code_len #(.E_W(15), .K_W(10), .N_MAX_LOG(9), .N_MIN_LOG(5)) u_dl (
        .clk_i(clk), .rst_ni(rst_n), .e_i(e), .k_i(k), .valid_i(valid_i),
        .ready_o(rdy_d), .n_log_o(nlog_d), .n_o(n_d), .err_o(err_d),
        .valid_o(vo_d), .ready_i(ready_i));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int clog(input longint x);
        int c = 0;
        while ((64'd1 << c) < x) c++;
        return c;
    endfunction

    // Reference: TS 38.212 5.3.1 with Rmin = 1/8, nmin = 5.
    function automatic exp_t model(input int ev, input int kv, input int nmax);
        exp_t r;
        int c, n1, n2, n;
        if (ev == 0 || kv == 0) begin
            r.err = 1;
            n = 5;
        end else begin
            r.err = 0;
            c = clog(ev);
            n1 = c;
            if (c >= 1 && 8 * ev <= 9 * (1 << (c - 1)) && 16 * kv < 9 * ev) n1 = c - 1;
            n2 = clog(kv) + 3;
            n = n1;
            if (n2 < n) n = n2;
            if (nmax < n) n = nmax;
            if (n < 5) n = 5;
        end
        r.nlog = n;
        r.n = 1 << n;
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rmode == 1) ready_i = 1'($urandom_range(0, 1));
        else ready_i = (rmode == 0);
    end

    // Scoreboard producer: a transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && valid_i) begin
            if (rdy_u) q_u.push_back(model(int'(e), int'(k), 10));
            if (rdy_d) q_d.push_back(model(int'(e), int'(k), 9));
        end
    end

    bit st_u = 0;
    int pl_u, pn_u, pe_u;
    always @(negedge clk) begin
        if (!rst_n) st_u = 0;
        else begin
            if (st_u) begin
                chk("ul_hold_valid", vo_u, 1);
                chk("ul_hold_nlog", nlog_u, pl_u);
                chk("ul_hold_n", n_u, pn_u);
                chk("ul_hold_err", err_u, pe_u);
            end
            st_u = 0;
            if (vo_u) begin
                if (ready_i) begin
                    if (q_u.size() == 0) chk("ul_unexpected_valid", vo_u, 0);
                    else begin
                        xu = q_u.pop_front();
                        chk("ul_nlog", nlog_u, xu.nlog);
                        chk("ul_n", n_u, xu.n);
                        chk("ul_err", err_u, xu.err);
                    end
                end else begin
                    st_u = 1;
                    pl_u = nlog_u; pn_u = n_u; pe_u = err_u;
                end
            end
            if (ready_i || !vo_u) chk("ul_ready_o", rdy_u, 1);
        end
    end

    bit st_d = 0;
    int pl_d, pn_d, pe_d;
    always @(negedge clk) begin
        if (!rst_n) st_d = 0;
        else begin
            if (st_d) begin
                chk("dl_hold_valid", vo_d, 1);
                chk("dl_hold_nlog", nlog_d, pl_d);
                chk("dl_hold_n", n_d, pn_d);
                chk("dl_hold_err", err_d, pe_d);
            end
            st_d = 0;
            if (vo_d) begin
                if (ready_i) begin
                    if (q_d.size() == 0) chk("dl_unexpected_valid", vo_d, 0);
                    else begin
                        xd = q_d.pop_front();
                        chk("dl_nlog", nlog_d, xd.nlog);
                        chk("dl_n", n_d, xd.n);
                        chk("dl_err", err_d, xd.err);
                    end
                end else begin
                    st_d = 1;
                    pl_d = nlog_d; pn_d = n_d; pe_d = err_d;
                end
            end
            if (ready_i || !vo_d) chk("dl_ready_o", rdy_d, 1);
        end
    end

    task automatic send(input int ev, input int kv);
        bit ok;
        int tries = 0;
        valid_i = 1'b1;
        e = 15'(ev);
        k = 10'(kv);
        forever begin
            @(negedge clk);
            ok = rdy_u;
            @(posedge clk);
            #1;
            if (ok) break;
            tries++;
            if (tries > 200) begin
                chk("send_timeout", rdy_u, 1);
                break;
            end
        end
        valid_i = 1'b0;
    endtask

    initial begin
        int lat, ev, kv, wait_cyc;
        rst_n = 1'b0;
        valid_i = 1'b0;
        e = '0;
        k = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_ul", vo_u, 0);
        chk("rst_ready_ul", rdy_u, 1);
        chk("rst_nlog_ul", nlog_u, 5);
        chk("rst_n_ul", n_u, 32);
        chk("rst_err_ul", err_u, 0);
        chk("rst_valid_dl", vo_d, 0);
        chk("rst_ready_dl", rdy_d, 1);
        chk("rst_nlog_dl", nlog_d, 5);
        chk("rst_n_dl", n_d, 32);
        chk("rst_err_dl", err_d, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases with ready_i held high; first one also measures latency.
        send(864, 56);
        lat = 1;
        while (!vo_d && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency_edges", lat, 3);
        send(560, 100);
        send(600, 100);
        send(20, 12);
        send(1, 1);
        send(100, 0);
        send(0, 50);
        send(32767, 1023);
        send(16384, 1023);
        repeat (6) @(posedge clk);
        #1;

        // Random phase: first 8 back-to-back, then random gaps; ready_i random.
        rmode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) ev = $urandom_range(0, 40);
            else ev = $urandom_range(0, 32767);
            if ($urandom_range(0, 3) == 0) kv = $urandom_range(0, 16);
            else kv = $urandom_range(0, 1023);
            send(ev, kv);
            if (i >= 8 && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            if (i >= 8) #1;
        end
        rmode = 0;
        wait_cyc = 0;
        while ((q_u.size() != 0 || q_d.size() != 0) && wait_cyc < 200) begin
            @(posedge clk);
            wait_cyc++;
        end
        chk("drain_ul", q_u.size(), 0);
        chk("drain_dl", q_d.size(), 0);
        @(posedge clk);
        #1;

        // Reset with two results in flight and the output stalled.
        rmode = 2;
        @(posedge clk);
        #1;
        send(864, 56);
        send(600, 100);
        @(posedge clk);
        #1;
        chk("inflight_valid_ul", vo_u, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid_ul", vo_u, 0);
        chk("async_rst_valid_dl", vo_d, 0);
        chk("async_rst_ready_ul", rdy_u, 1);
        chk("async_rst_ready_dl", rdy_d, 1);
        q_u.delete();
        q_d.delete();
        rmode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_valid_ul", vo_u, 0);
        chk("post_rst_ready_ul", rdy_u, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
